// File: rtl/decode_queue_ctrl.sv
// Instruction queue between fetch and the dual-slot decode stage.
// Keeps program order and never issues a branch without its delay slot.
module decode_queue_ctrl #(
   parameter int DEPTH = 8,
   parameter int AW    = $clog2(DEPTH)
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             flush,
   input  logic [1:0]       in_valid,
   input  logic [1:0][31:0] in_pc,
   input  logic [1:0][31:0] in_instr,
   input  logic [1:0]       in_is_branch,
   output logic             in_ready,
   output logic [1:0]       out_valid,
   output logic [1:0][31:0] out_pc,
   output logic [1:0][31:0] out_instr,
   input  logic [1:0]       accept,
   output logic [AW:0]      count,
   output logic             protocol_err
);

   localparam logic [AW:0] MAX_FILL = (AW+1)'(DEPTH - 2);
   localparam logic [AW:0] ONE      = (AW+1)'(1);
   localparam logic [AW:0] TWO      = (AW+1)'(2);

   logic [31:0]      pc_mem    [DEPTH];
   logic [31:0]      instr_mem [DEPTH];
   logic [DEPTH-1:0] br_mem;

   logic [AW:0]   head, tail;
   logic [AW-1:0] h0, h1, t0, t1;
   logic          head_br, active, err_set;
   logic [1:0]    push_n, pop_n, pop;

   assign count   = tail - head;
   assign h0      = head[AW-1:0];
   assign h1      = h0 + AW'(1);
   assign t0      = tail[AW-1:0];
   assign t1      = t0 + AW'(1);
   assign head_br = br_mem[h0];
   assign active  = !reset && !flush;

   // NOTE: every signal driven here gets a default first, so no path can infer a latch.
   always_comb begin
      in_ready     = !reset && (count <= MAX_FILL);
      out_valid    = 2'b00;
      out_pc[0]    = pc_mem[h0];
      out_pc[1]    = pc_mem[h1];
      out_instr[0] = instr_mem[h0];
      out_instr[1] = instr_mem[h1];
      push_n       = 2'd0;
      pop_n        = 2'd0;
      pop          = 2'b00;
      err_set      = 1'b0;

      if (active) begin
         // A branch at head is held back until its delay slot is queued behind it.
         out_valid[1] = count >= TWO;
         out_valid[0] = (count >= ONE) && !(head_br && count < TWO);

         case (in_valid)
            2'b01:   push_n = in_ready ? 2'd1 : 2'd0;
            2'b11:   push_n = in_ready ? 2'd2 : 2'd0;
            2'b10:   err_set = 1'b1;
            default: push_n = 2'd0;
         endcase

         pop = accept & out_valid;
         if (accept == 2'b10) begin
            err_set = 1'b1;
         end else if (pop == 2'b11) begin
            pop_n = 2'd2;
         end else if (pop == 2'b01) begin
            if (head_br) err_set = 1'b1;
            else         pop_n   = 2'd1;
         end
      end
   end

   // NOTE: state registers use non-blocking assignments so all flops update together at the edge.
   always_ff @(posedge clk) begin
      if (reset) begin
         head         <= '0;
         tail         <= '0;
         protocol_err <= 1'b0;
      end else if (flush) begin
         head <= '0;
         tail <= '0;
      end else begin
         head <= head + (AW+1)'(pop_n);
         tail <= tail + (AW+1)'(push_n);
         if (err_set) protocol_err <= 1'b1;
      end
   end

   // NOTE: payload storage is deliberately not reset; the pointers alone decide what is valid.
   always_ff @(posedge clk) begin
      if (push_n != 2'd0) begin
         pc_mem[t0]    <= in_pc[0];
         instr_mem[t0] <= in_instr[0];
         br_mem[t0]    <= in_is_branch[0];
      end
      if (push_n == 2'd2) begin
         pc_mem[t1]    <= in_pc[1];
         instr_mem[t1] <= in_instr[1];
         br_mem[t1]    <= in_is_branch[1];
      end
   end

endmodule

// File: tb/tb_decode_queue_ctrl.sv
// Directed bench for decode_queue_ctrl: stimulus feeds a queue model,
// a negedge monitor compares every presented slot and status output.
module tb_decode_queue_ctrl;

   localparam int DEPTH = 8;
   localparam int AW    = 3;

   typedef struct packed {
      logic [31:0] pc;
      logic [31:0] instr;
      logic        br;
   } ent_t;

   logic             clk = 1'b0;
   logic             reset = 1'b1;
   logic             flush = 1'b0;
   logic [1:0]       in_valid = 2'b00;
   logic [1:0][31:0] in_pc = '0;
   logic [1:0][31:0] in_instr = '0;
   logic [1:0]       in_is_branch = 2'b00;
   logic             in_ready;
   logic [1:0]       out_valid;
   logic [1:0][31:0] out_pc;
   logic [1:0][31:0] out_instr;
   logic [1:0]       accept = 2'b00;
   logic [AW:0]      count;
   logic             protocol_err;

   int   n_tests = 0;
   int   n_fail  = 0;
   ent_t exp_q[$];
   logic exp_err = 1'b0;
   logic [1:0] eov, mpop;

   decode_queue_ctrl #(.DEPTH(DEPTH), .AW(AW)) dut (
      .clk(clk), .reset(reset), .flush(flush),
      .in_valid(in_valid), .in_pc(in_pc), .in_instr(in_instr),
      .in_is_branch(in_is_branch), .in_ready(in_ready),
      .out_valid(out_valid), .out_pc(out_pc), .out_instr(out_instr),
      .accept(accept), .count(count), .protocol_err(protocol_err)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
      end
   endtask

   function automatic ent_t mk(input logic [31:0] pc, input logic br);
      ent_t e;
      e.pc    = pc;
      e.instr = br ? (32'h1000_0000 | pc) : (32'h0000_0013 ^ (pc << 8));
      e.br    = br;
      return e;
   endfunction

   // One cycle of stimulus; called at posedge+1, returns at the next posedge+1.
   task automatic cyc(input logic rst, input logic fl, input logic [1:0] iv,
                      input ent_t e0, input ent_t e1, input logic [1:0] acc);
      logic rdy;
      reset           = rst;
      flush           = fl;
      in_valid        = iv;
      in_pc[0]        = e0.pc;
      in_instr[0]     = e0.instr;
      in_is_branch[0] = e0.br;
      in_pc[1]        = e1.pc;
      in_instr[1]     = e1.instr;
      in_is_branch[1] = e1.br;
      accept          = acc;
      rdy = !rst && (exp_q.size() <= DEPTH - 2);
      @(posedge clk);
      if (rst || fl) begin
         exp_q.delete();
      end else if (rdy) begin
         if (iv == 2'b01 || iv == 2'b11) exp_q.push_back(e0);
         if (iv == 2'b11) exp_q.push_back(e1);
      end
      #1;
   endtask

   // Monitor: compares what the DUT presents against the model, then retires pops.
   always @(negedge clk) begin
      eov = 2'b00;
      if (!reset && !flush) begin
         eov[1] = exp_q.size() >= 2;
         eov[0] = (exp_q.size() >= 1) && !(exp_q[0].br && exp_q.size() < 2);
      end
      check("mon_out_valid", 32'(out_valid), 32'(eov));
      check("mon_count", 32'(count), 32'(exp_q.size()));
      check("mon_in_ready", 32'(in_ready), 32'(!reset && exp_q.size() <= DEPTH - 2));
      check("mon_protocol_err", 32'(protocol_err), 32'(exp_err));
      if (eov[0] && out_valid[0]) begin
         check("mon_pc0", out_pc[0], exp_q[0].pc);
         check("mon_instr0", out_instr[0], exp_q[0].instr);
      end
      if (eov[1] && out_valid[1]) begin
         check("mon_pc1", out_pc[1], exp_q[1].pc);
         check("mon_instr1", out_instr[1], exp_q[1].instr);
      end
      if (reset) begin
         exp_err = 1'b0;
      end else if (!flush) begin
         if (in_valid == 2'b10) exp_err = 1'b1;
         mpop = accept & eov;
         if (accept == 2'b10) begin
            exp_err = 1'b1;
         end else if (mpop == 2'b11) begin
            void'(exp_q.pop_front());
            void'(exp_q.pop_front());
         end else if (mpop == 2'b01) begin
            if (exp_q[0].br) exp_err = 1'b1;
            else             void'(exp_q.pop_front());
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not complete");
      $fatal(1, "watchdog expired");
   end

   initial begin
      ent_t z;
      logic [31:0] npc;
      logic [1:0]  iv, acc;
      z = '0;

      @(posedge clk); #1;
      cyc(1, 0, 2'b00, z, z, 2'b00);
      check("reset_in_ready", 32'(in_ready), 32'd0);
      check("reset_count", 32'(count), 32'd0);
      reset = 1'b0;
      #1;
      check("post_reset_in_ready", 32'(in_ready), 32'd1);

      // Basic pair push and pop.
      cyc(0, 0, 2'b11, mk(32'h1000, 0), mk(32'h1004, 0), 2'b00);
      check("t1_count", 32'(count), 32'd2);
      check("t1_out_valid", 32'(out_valid), 32'd3);
      check("t1_pc0", out_pc[0], 32'h1000);
      check("t1_pc1", out_pc[1], 32'h1004);
      cyc(0, 0, 2'b00, z, z, 2'b11);
      check("t1_drain_count", 32'(count), 32'd0);
      check("t1_drain_valid", 32'(out_valid), 32'd0);

      // Head branch waits for its delay slot.
      cyc(0, 0, 2'b01, mk(32'h2000, 1), z, 2'b00);
      check("t2_branch_hold_valid", 32'(out_valid), 32'd0);
      check("t2_branch_hold_count", 32'(count), 32'd1);
      cyc(0, 0, 2'b01, mk(32'h2004, 0), z, 2'b00);
      check("t2_pair_valid", 32'(out_valid), 32'd3);
      check("t2_pair_pc1", out_pc[1], 32'h2004);
      cyc(0, 0, 2'b00, z, z, 2'b11);

      // Fill to DEPTH, then release.
      for (int i = 0; i < 4; i++)
         cyc(0, 0, 2'b11, mk(32'h3000 + 8*i, 0), mk(32'h3004 + 8*i, 0), 2'b00);
      check("t3_full_count", 32'(count), 32'd8);
      check("t3_full_in_ready", 32'(in_ready), 32'd0);
      cyc(0, 0, 2'b00, z, z, 2'b01);
      check("t3_seven_in_ready", 32'(in_ready), 32'd0);
      cyc(0, 0, 2'b00, z, z, 2'b11);
      check("t3_five_count", 32'(count), 32'd5);
      check("t3_five_in_ready", 32'(in_ready), 32'd1);

      // Streaming across pointer wrap; branches always travel with their delay slot.
      npc = 32'h4000;
      for (int i = 0; i < 20; i++) begin
         iv  = (exp_q.size() <= DEPTH - 2) ? 2'b11 : 2'b00;
         acc = (i % 3 == 2) ? 2'b00 : 2'b11;
         cyc(0, 0, iv, mk(npc, i % 2 == 1), mk(npc + 4, 0), acc);
         if (iv == 2'b11) npc = npc + 8;
      end
      for (int i = 0; i < 6; i++) cyc(0, 0, 2'b00, z, z, 2'b11);
      check("t3_stream_drained", 32'(count), 32'd0);

      // Flush overrides same-cycle push and accept.
      cyc(0, 0, 2'b11, mk(32'h6000, 0), mk(32'h6004, 0), 2'b00);
      cyc(0, 0, 2'b11, mk(32'h6008, 0), mk(32'h600c, 0), 2'b00);
      check("t4_pre_flush_count", 32'(count), 32'd4);
      cyc(0, 1, 2'b11, mk(32'h6010, 0), mk(32'h6014, 0), 2'b11);
      check("t4_flush_count", 32'(count), 32'd0);
      check("t4_flush_valid", 32'(out_valid), 32'd0);
      cyc(0, 0, 2'b00, z, z, 2'b00);

      // Push two while popping one at count 3.
      cyc(0, 0, 2'b11, mk(32'h7000, 0), mk(32'h7004, 0), 2'b00);
      cyc(0, 0, 2'b01, mk(32'h7008, 0), z, 2'b00);
      cyc(0, 0, 2'b11, mk(32'h700c, 0), mk(32'h7010, 0), 2'b01);
      check("t5_count", 32'(count), 32'd4);
      check("t5_head_pc", out_pc[0], 32'h7004);
      for (int i = 0; i < 3; i++) cyc(0, 0, 2'b00, z, z, 2'b11);
      check("t5_drained", 32'(count), 32'd0);

      // Illegal single accept of a head branch.
      cyc(0, 0, 2'b11, mk(32'h5000, 1), mk(32'h5004, 0), 2'b00);
      cyc(0, 0, 2'b00, z, z, 2'b01);
      check("t6_no_pop_count", 32'(count), 32'd2);
      check("t6_err_set", 32'(protocol_err), 32'd1);
      check("t6_head_pc", out_pc[0], 32'h5000);
      cyc(0, 0, 2'b00, z, z, 2'b00);
      check("t6_err_sticky", 32'(protocol_err), 32'd1);
      cyc(1, 0, 2'b00, z, z, 2'b00);
      reset = 1'b0;
      #1;
      check("t6_err_cleared", 32'(protocol_err), 32'd0);

      // Slot-1-only fetch is rejected.
      cyc(0, 0, 2'b10, mk(32'h8000, 0), mk(32'h8004, 0), 2'b00);
      check("t6_iv10_count", 32'(count), 32'd0);
      check("t6_iv10_err", 32'(protocol_err), 32'd1);

      // Reset in the middle of traffic.
      cyc(0, 0, 2'b11, mk(32'h9000, 0), mk(32'h9004, 0), 2'b00);
      cyc(1, 0, 2'b11, mk(32'h9008, 0), mk(32'h900c, 0), 2'b11);
      reset = 1'b0;
      #1;
      check("t7_reset_count", 32'(count), 32'd0);
      check("t7_reset_valid", 32'(out_valid), 32'd0);
      check("t7_reset_in_ready", 32'(in_ready), 32'd1);
      cyc(0, 0, 2'b00, z, z, 2'b00);
      cyc(0, 0, 2'b00, z, z, 2'b00);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/decode_queue_ctrl.md
Name: decode_queue_ctrl

Overview:
- Instruction queue and issue controller between fetch and the dual-slot decode stage.
- Buffers up to two fetched instructions per cycle and presents up to two in program order to decode.
- Never presents a branch in slot 0 without its delay slot in slot 1.
- Handles front-end flush and redirect by emptying the queue.

Parameters:
DEPTH, 8, entry count; power of two, minimum 4
AW, $clog2(DEPTH), pointer index width

Ports:
clk  input  1  clock, all state updates on rising edge
reset  input  1  synchronous, active-high reset
flush  input  1  discard all queued entries (redirect/exception)
in_valid  input  2  fetch slots valid; bit0 = older instruction
in_pc  input  2x32  PC per fetch slot
in_instr  input  2x32  instruction word per fetch slot
in_is_branch  input  2  predecode flag: instruction has a delay slot
in_ready  output  1  queue can take two entries this cycle
out_valid  output  2  decode slots valid; bit0 = head
out_pc  output  2x32  PC of head / head+1
out_instr  output  2x32  instruction of head / head+1
accept  input  2  decode consumes slot(s) this cycle
count  output  AW+1  current occupancy
protocol_err  output  1  sticky: illegal in_valid/accept pattern seen

Behaviour:
- Storage: circular buffer of DEPTH entries {pc, instr, is_branch}. Pointers head/tail are AW+1 bits and wrap naturally. count = tail - head (AW+1 bit subtraction).
- Full when count == DEPTH, empty when count == 0. Entry data is not reset; only pointers and flags reset.
- in_ready = !reset && (DEPTH - count >= 2). Computed from registered count only; same-cycle pops are not credited.
- Push:
  - in_valid 2'b01 pushes one entry; 2'b11 pushes slot0 then slot1.
  - 2'b10 pushes nothing and sets protocol_err.
  - Pushes happen only when in_ready is high; otherwise fetch must hold.
- Outputs are read combinationally from head / head+1 (mod DEPTH), with no bypass. A pushed entry is first visible at out the cycle after the push, so minimum latency is 1 cycle.
- out_valid[1] = count >= 2.
- out_valid[0] = count >= 1 && !(entry[head].is_branch && count < 2). A head branch waits for its delay slot.
- A branch at head+1 (slot 1) is presented normally; decode tracks its delay slot.
- Both out_valid bits are 0 during reset and during a flush cycle.
- Pop:
  - pop = accept & out_valid, and must form a prefix; accept 2'b10 pops nothing and sets protocol_err.
  - With a branch at head, accept must be 2'b11. accept 2'b01 pops nothing and sets protocol_err.
  - Legal pops advance head by 1 or 2.
- Simultaneous push and pop in one cycle: both apply; tail += pushes, head += pops.
- Flush:
  - Next cycle head = tail = 0 and count = 0.
  - Pushes and accepts in the flush cycle are ignored.
  - protocol_err is unaffected.
- Reset: head = tail = 0, count = 0, protocol_err = 0, in_ready = 0 and out_valid = 0 while reset is high. in_ready = 1 in the first cycle after reset. Reset asserted mid-stream discards all entries with no output activity.
- Reset has priority over flush; flush has priority over push/pop.
- protocol_err is sticky until reset.

Test Plan:
- Reset, then push {PC 0x1000 nop, 0x1004 nop} -> next cycle out_valid=2'b11, out_pc={0x1000,0x1004}, count=2. accept=2'b11 -> count=0, out_valid=0 the following cycle.
- Push single branch at 0x2000 (in_valid=01, is_branch=1) -> out_valid=00 with count=1. Next cycle push 0x2004 -> out_valid=11, pair presented together.
- Fill to DEPTH=8 with accept=00 -> in_ready=0 at count=7 and 8. Accept 2'b11 -> in_ready=1 next cycle. Continue 20 push/pop cycles across pointer wrap and check PCs stay in order.
- count=4, flush with in_valid=11 and accept=11 same cycle -> next cycle count=0, out_valid=00, no entries from that cycle appear.
- Branch at head with count=2, accept=2'b01 -> no pop, count stays 2, protocol_err=1 until reset. in_valid=2'b10 separately -> no push, protocol_err=1.
- Simultaneous push 2 / pop 1 at count=3 -> count=4, head advances 1, new entries at tail, order preserved. Reset asserted mid-stream -> count=0 and out_valid=0 the next cycle.
